// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the PISO transmit scheduler.
// Optional even-parity trailer bit is enabled by defining PISO_TX_PARITY_EN.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bit counter must be able to hold WIDTH (the parity slot index).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// MSB-first parallel-in/serial-out shift register with zero fill.
module piso_shift
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shift_q;

  // Load has priority over shift; both are ignored during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
    end else if (shift_i) begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shift_q <= shift_q;
    end
  end

  assign msb_o = shift_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one serial shift path among NREQ word sources.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_sched
  import piso_tx_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NREQ-1:0]               req_i,
  input  logic [NREQ*WIDTH-1:0]         din_i,
  output logic [NREQ-1:0]               ack_o,
  output logic                          dout_o,
  output logic                          frame_o,
  output logic [idx_width(NREQ)-1:0]    src_o,
  output logic                          busy_o
);

  localparam int SW = idx_width(NREQ);
  localparam int CW = cnt_width(WIDTH);
  localparam int GW = idx_width(GAP);
`ifdef PISO_TX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     src_q, src_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [SW-1:0]     win_s;
  logic              found_s;
  logic [WIDTH-1:0]  word_s;
  logic              load_s;
  logic              shift_s;
  logic              msb_s;
  logic              bit_s;
  logic              frame_s;
`ifdef PISO_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // First pending request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found_s && req_i[idx]) begin
        found_s = 1'b1;
        win_s   = SW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign word_s = din_i[win_s*WIDTH +: WIDTH];

  // Scheduler next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    ack_d   = '0;
    load_s  = 1'b0;
    shift_s = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
          cnt_d   = '0;
          src_d   = win_s;
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          ptr_d   = (win_s == SW'(NREQ - 1)) ? '0 : win_s + SW'(1);
`ifdef PISO_TX_PARITY_EN
          par_d   = ^word_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) begin
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
          gap_d   = '0;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      ack_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  piso_shift #(.WIDTH(WIDTH)) u_shift (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load_s),
    .shift_i(shift_s),
    .data_i (word_s),
    .msb_o  (msb_s)
  );

`ifdef PISO_TX_PARITY_EN
  assign bit_s = (cnt_q == CW'(WIDTH)) ? par_q : msb_s;
`else
  assign bit_s = msb_s;
`endif

  assign frame_s = (state_q == ST_SHIFT);
  assign frame_o = frame_s;
  assign dout_o  = frame_s & bit_s;
  assign busy_o  = (state_q != ST_IDLE);
  assign ack_o   = ack_q;
  assign src_o   = src_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: stimulus queues expected frames, a monitor checks them.
module tb_piso_tx_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int GAP   = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] din_i;
  logic [NREQ-1:0]       ack_o;
  logic                  dout_o;
  logic                  frame_o;
  logic [1:0]            src_o;
  logic                  busy_o;

  typedef struct {
    int               src;
    logic [WIDTH-1:0] word;
    bit               gapchk;
  } exp_t;

  exp_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [NREQ-1:0] ack_hist;
  bit              mon_off = 1'b0;

  always #5 clk_i = ~clk_i;

  piso_tx_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .din_i  (din_i),
    .ack_o  (ack_o),
    .dout_o (dout_o),
    .frame_o(frame_o),
    .src_o  (src_o),
    .busy_o (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] exp_bits(input logic [WIDTH-1:0] w);
`ifdef PISO_TX_PARITY_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  // One clock: sample ack away from the edge, then drop acknowledged requests.
  task automatic tick();
    logic [NREQ-1:0] ack_seen;
    @(negedge clk_i);
    ack_seen = ack_o;
    ack_hist = ack_hist | ack_o;
    @(posedge clk_i);
    #1;
    req_i = req_i & ~ack_seen;
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    din_i[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic push(input int s, input logic [WIDTH-1:0] w, input bit g);
    exp_t e;
    e.src = s; e.word = w; e.gapchk = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((req_i != '0 || busy_o || exp_q.size() != 0) && n < 300);
    chk({nm, "_timeout"}, (n < 300), 1);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic wait_frame(input string nm);
    int n;
    n = 0;
    while (!frame_o && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_frame_timeout"}, (n < 50), 1);
  endtask

  // Monitor: collects each serial frame and compares it with the queue head.
  bit               in_frame = 1'b0;
  bit               have_prev = 1'b0;
  bit               started;
  int               nbits = 0;
  int               post = -1;
  int               idle_cnt = 0;
  logic [WIDTH:0]   coll;
  exp_t             cur;

  always @(negedge clk_i) begin
    if (rst_i || mon_off) begin
      in_frame  = 1'b0;
      have_prev = 1'b0;
      post      = -1;
    end else begin
      started = 1'b0;
      if (frame_o) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          started  = 1'b1;
          nbits    = 0;
          coll     = '0;
          chk("frame_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q[0];
            chk("ack_at_frame_start", ack_o, 32'(1) << cur.src);
            chk("src_owner", src_o, cur.src);
            if (cur.gapchk && have_prev) chk("frame_pitch_idle", idle_cnt, GAP + 1);
          end
        end
        coll = {coll[WIDTH-1:0], dout_o};
        nbits++;
        if (nbits == NB) begin
          in_frame = 1'b0;
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("frame_bits", coll, exp_bits(cur.word));
          end
          post      = 0;
          have_prev = 1'b1;
          idle_cnt  = 0;
        end
      end else begin
        chk("frame_ended_early", in_frame, 0);
        in_frame = 1'b0;
        chk("dout_idle_zero", dout_o, 0);
        idle_cnt++;
        if (post >= 0) begin
          post++;
          if (post <= GAP) begin
            chk("busy_in_gap", busy_o, 1);
          end else begin
            chk("busy_after_gap", busy_o, 0);
            post = -1;
          end
        end
      end
      if (!started) chk("ack_only_at_frame_start", ack_o, 0);
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    tick();
    tick();
    chk("rst_ack", ack_o, 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_frame", frame_o, 0);
    chk("rst_src", src_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i    = 1'b1;
    req_i    = '0;
    din_i    = '0;
    ack_hist = '0;
    do_reset();

    // Single word from requester 0.
    ack_hist = '0;
    set_word(0, 8'hAA);
    push(0, 8'hAA, 1'b0);
    req_i = 4'b0001;
    wait_idle("single");
    chk("single_ack_hist", ack_hist, 4'b0001);

    // Contention from a fresh pointer, then a second round.
    do_reset();
    set_word(0, 8'h3C); set_word(1, 8'hC3); set_word(2, 8'h01); set_word(3, 8'h80);
    push(0, 8'h3C, 1'b0); push(1, 8'hC3, 1'b1); push(2, 8'h01, 1'b1); push(3, 8'h80, 1'b1);
    req_i = 4'b1111;
    wait_idle("contend1");
    set_word(0, 8'h96); set_word(1, 8'h7E); set_word(2, 8'hFF); set_word(3, 8'h00);
    push(0, 8'h96, 1'b0); push(1, 8'h7E, 1'b1); push(2, 8'hFF, 1'b1); push(3, 8'h00, 1'b1);
    req_i = 4'b1111;
    wait_idle("contend2");

    // Fairness wrap: grant 2 moves pointer to 3, then 0101 grants 0 before 2.
    set_word(2, 8'h5A);
    push(2, 8'h5A, 1'b0);
    req_i = 4'b0100;
    wait_idle("wrap_pre");
    set_word(0, 8'hA8); set_word(2, 8'h81);
    push(0, 8'hA8, 1'b0); push(2, 8'h81, 1'b1);
    req_i = 4'b0101;
    wait_idle("wrap");

    // Withdrawn request on 1 while 0 is shifting.
    ack_hist = '0;
    set_word(0, 8'h0F); set_word(1, 8'hEE);
    push(0, 8'h0F, 1'b0);
    req_i = 4'b0001;
    wait_frame("withdraw");
    req_i[1] = 1'b1;
    tick(); tick(); tick();
    req_i[1] = 1'b0;
    wait_idle("withdraw");
    chk("withdrawn_no_ack1", ack_hist[1], 0);

    // Reset during bit 4 of 8'hF0 from requester 2 (pointer then sits at 3).
    mon_off = 1'b1;
    set_word(2, 8'hF0);
    req_i = 4'b0100;
    wait_frame("abort");
    tick(); tick(); tick(); tick();
    chk("abort_bit4_frame", frame_o, 1);
    chk("abort_bit4_dout", dout_o, 0);
    rst_i = 1'b1;
    tick();
    chk("abort_frame", frame_o, 0);
    chk("abort_dout", dout_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ack", ack_o, 0);
    rst_i   = 1'b0;
    mon_off = 1'b0;
    tick();

    // Pointer back at 0: requester 2 must beat requester 3.
    set_word(2, 8'h5A); set_word(3, 8'hE7);
    push(2, 8'h5A, 1'b0); push(3, 8'hE7, 1'b1);
    req_i = 4'b1100;
    wait_idle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
